controle_memoria_historico: RTL and testbench

Parametrised result-memory controller for the calculator datapath, sitting between the ULA output and the display path. It automatically stores every valid executed ULA result into a circular history of `PROFUNDIDADE` entries. A recall key lets the user step backwards through stored results on the display. The block adds edge-qualified capture, clear, and full/empty status.

---
 rtl/controle_memoria_historico_pkg.sv | 10 +
 rtl/controle_memoria_historico_banco.sv | 48 ++++
 rtl/controle_memoria_historico.sv | 102 ++++++++++
 tb/tb_controle_memoria_historico.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_memoria_historico_pkg.sv
// Shared types and defaults for the calculator result-history controller.
package memoria_pkg;
    typedef enum logic {AO_VIVO, HISTORICO} estado_memoria_t;

    localparam int LARGURA_PADRAO      = 8;
    localparam int PROFUNDIDADE_PADRAO = 4;
    localparam int LARGURA_OP_PADRAO   = 3;

    localparam logic [LARGURA_OP_PADRAO-1:0] OP_NULA = '0;
endpackage

// File: rtl/controle_memoria_historico_banco.sv
// Circular history register file: owns the write pointer and resolves
// a recall depth (0 = newest) into a physical slot.
module banco_historico
    import memoria_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            limpar,
    input  logic                            escrever,
    input  logic [LARGURA-1:0]              dado,
    input  logic [$clog2(PROFUNDIDADE)-1:0] indice,
    output logic [LARGURA-1:0]              dado_lido
);
    localparam int AW = $clog2(PROFUNDIDADE);

    logic [LARGURA-1:0] banco [PROFUNDIDADE];
    logic [AW-1:0]      ptr_esc;
    logic [AW:0]        soma;
    logic [AW-1:0]      endereco;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                banco[i] <= '0;
            end
            ptr_esc <= '0;
        end else if (limpar) begin
            ptr_esc <= '0;
        end else if (escrever) begin
            banco[ptr_esc] <= dado;
            ptr_esc <= (ptr_esc == AW'(PROFUNDIDADE - 1)) ? '0 : ptr_esc + AW'(1);
        end
    end

    // (ptr_esc - 1 - indice) mod PROFUNDIDADE without relying on a power-of-two depth
    always_comb begin
        soma = {1'b0, ptr_esc} + (AW+1)'(PROFUNDIDADE - 1) - {1'b0, indice};
        if (soma >= (AW+1)'(PROFUNDIDADE)) begin
            soma = soma - (AW+1)'(PROFUNDIDADE);
        end
        endereco = soma[AW-1:0];
    end

    assign dado_lido = banco[endereco];
endmodule

// File: rtl/controle_memoria_historico.sv
// Result-memory controller: edge-qualified capture of ULA results into a
// circular history, with recall navigation, clear and full/empty status.
module controle_memoria_historico
    import memoria_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int LARGURA_OP   = LARGURA_OP_PADRAO
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LARGURA_OP-1:0]             operacao,
    input  logic [LARGURA-1:0]                resultado_ula,
    input  logic                              executar,
    input  logic                              recuperar,
    input  logic                              limpar,
    output logic                              carregar_memoria,
    output logic [LARGURA-1:0]                valor_memoria,
    output logic [LARGURA-1:0]                resultado_final,
    output logic                              modo_historico,
    output logic [$clog2(PROFUNDIDADE)-1:0]   indice_hist,
    output logic [$clog2(PROFUNDIDADE+1)-1:0] contagem,
    output logic                              vazio,
    output logic                              cheio
);
    localparam int AW = $clog2(PROFUNDIDADE);
    localparam int CW = $clog2(PROFUNDIDADE + 1);

    logic            executar_q;
    logic            recuperar_q;
    logic            exe_borda;
    logic            rec_borda;
    estado_memoria_t estado;
    logic [LARGURA-1:0] dado_lido;

    assign exe_borda        = executar & ~executar_q;
    assign rec_borda        = recuperar & ~recuperar_q;
    assign carregar_memoria = exe_borda & (operacao != LARGURA_OP'(OP_NULA)) & ~limpar;

    banco_historico #(
        .LARGURA     (LARGURA),
        .PROFUNDIDADE(PROFUNDIDADE)
    ) u_banco (
        .clk      (clk),
        .rst      (rst),
        .limpar   (limpar),
        .escrever (carregar_memoria),
        .dado     (resultado_ula),
        .indice   (indice_hist),
        .dado_lido(dado_lido)
    );

    // Priority: limpar > store > recall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            executar_q    <= 1'b0;
            recuperar_q   <= 1'b0;
            estado        <= AO_VIVO;
            indice_hist   <= '0;
            contagem      <= '0;
            valor_memoria <= '0;
        end else begin
            executar_q  <= executar;
            recuperar_q <= recuperar;
            if (limpar) begin
                estado        <= AO_VIVO;
                indice_hist   <= '0;
                contagem      <= '0;
                valor_memoria <= '0;
            end else if (carregar_memoria) begin
                estado        <= AO_VIVO;
                indice_hist   <= '0;
                valor_memoria <= resultado_ula;
                if (contagem != CW'(PROFUNDIDADE)) begin
                    contagem <= contagem + CW'(1);
                end
            end else if (rec_borda) begin
                case (estado)
                    AO_VIVO: begin
                        if (contagem != '0) begin
                            estado      <= HISTORICO;
                            indice_hist <= '0;
                        end
                    end
                    HISTORICO: begin
                        if (CW'(indice_hist) + CW'(1) == contagem) begin
                            indice_hist <= '0;
                        end else begin
                            indice_hist <= indice_hist + AW'(1);
                        end
                    end
                    default: estado <= AO_VIVO;
                endcase
            end
        end
    end

    assign resultado_final = (estado == HISTORICO) ? dado_lido : resultado_ula;
    assign modo_historico  = (estado == HISTORICO);
    assign vazio           = (contagem == '0);
    assign cheio           = (contagem == CW'(PROFUNDIDADE));
endmodule

// File: tb/tb_controle_memoria_historico.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_controle_memoria_historico;
    typedef enum int {S_CARREGAR, S_VALOR, S_FINAL, S_MODO, S_IDX, S_CONT, S_VAZIO, S_CHEIO} sel_t;

    typedef struct {
        sel_t        sel;
        logic [31:0] esperado;
        string       nome;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] operacao;
    logic [7:0] resultado_ula;
    logic       executar;
    logic       recuperar;
    logic       limpar;
    logic       carregar_memoria;
    logic [7:0] valor_memoria;
    logic [7:0] resultado_final;
    logic       modo_historico;
    logic [1:0] indice_hist;
    logic [2:0] contagem;
    logic       vazio;
    logic       cheio;

    item_t fila[$];
    int    vetores = 0;
    int    erros   = 0;

    controle_memoria_historico #(
        .LARGURA     (8),
        .PROFUNDIDADE(4),
        .LARGURA_OP  (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .operacao        (operacao),
        .resultado_ula   (resultado_ula),
        .executar        (executar),
        .recuperar       (recuperar),
        .limpar          (limpar),
        .carregar_memoria(carregar_memoria),
        .valor_memoria   (valor_memoria),
        .resultado_final (resultado_final),
        .modo_historico  (modo_historico),
        .indice_hist     (indice_hist),
        .contagem        (contagem),
        .vazio           (vazio),
        .cheio           (cheio)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ler(sel_t s);
        case (s)
            S_CARREGAR: return 32'(carregar_memoria);
            S_VALOR:    return 32'(valor_memoria);
            S_FINAL:    return 32'(resultado_final);
            S_MODO:     return 32'(modo_historico);
            S_IDX:      return 32'(indice_hist);
            S_CONT:     return 32'(contagem);
            S_VAZIO:    return 32'(vazio);
            default:    return 32'(cheio);
        endcase
    endfunction

    always @(negedge clk) begin
        while (fila.size() > 0) begin
            item_t it;
            logic [31:0] atual;
            it = fila.pop_front();
            atual = ler(it.sel);
            vetores++;
            if (atual !== it.esperado) begin
                erros++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", it.nome, atual, it.esperado, $time);
            end
        end
    end

    task automatic espera(sel_t s, logic [31:0] v, string nome);
        item_t it;
        it.sel = s;
        it.esperado = v;
        it.nome = nome;
        fila.push_back(it);
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    task automatic armazena(logic [7:0] v);
        resultado_ula = v;
        executar = 1'b1;
        espera(S_CARREGAR, 1, "store_strobe");
        passo();
        executar = 1'b0;
        passo();
    endtask

    task automatic recall_passo(logic [1:0] idx, logic [7:0] v, string nome);
        recuperar = 1'b1;
        passo();
        espera(S_MODO, 1, {nome, "_modo"});
        espera(S_IDX, 32'(idx), {nome, "_idx"});
        espera(S_FINAL, 32'(v), {nome, "_final"});
        recuperar = 1'b0;
        passo();
    endtask

    initial begin
        rst = 1'b1; operacao = 3'b001; resultado_ula = 8'h5A;
        executar = 1'b0; recuperar = 1'b0; limpar = 1'b0;
        passo();
        passo();
        espera(S_VALOR, 0, "rst_valor");
        espera(S_CONT, 0, "rst_cont");
        espera(S_IDX, 0, "rst_idx");
        espera(S_MODO, 0, "rst_modo");
        espera(S_VAZIO, 1, "rst_vazio");
        espera(S_CHEIO, 0, "rst_cheio");
        espera(S_FINAL, 8'h5A, "rst_final_live");
        espera(S_CARREGAR, 0, "rst_carregar_idle");
        passo();
        executar = 1'b1;
        #1;
        espera(S_CARREGAR, 1, "rst_carregar_held");
        passo();
        executar = 1'b0;
        rst = 1'b0;
        passo();

        // Two simple stores
        armazena(8'h11);
        espera(S_VALOR, 8'h11, "st1_valor");
        espera(S_CONT, 1, "st1_cont");
        armazena(8'h22);
        espera(S_VALOR, 8'h22, "st2_valor");
        espera(S_CONT, 2, "st2_cont");
        espera(S_VAZIO, 0, "st2_vazio");

        // Held key stores once
        resultado_ula = 8'h33;
        executar = 1'b1;
        espera(S_CARREGAR, 1, "held_first");
        for (int i = 0; i < 4; i++) begin
            passo();
            espera(S_CARREGAR, 0, "held_repeat");
        end
        passo();
        executar = 1'b0;
        espera(S_CONT, 3, "held_cont");
        espera(S_VALOR, 8'h33, "held_valor");
        passo();

        // Null operation does not store
        operacao = 3'b000;
        resultado_ula = 8'h44;
        executar = 1'b1;
        #1;
        espera(S_CARREGAR, 0, "nullop_carregar");
        passo();
        executar = 1'b0;
        espera(S_CONT, 3, "nullop_cont");
        espera(S_VALOR, 8'h33, "nullop_valor");
        operacao = 3'b001;
        passo();

        // Clear then fill past capacity
        limpar = 1'b1;
        passo();
        limpar = 1'b0;
        espera(S_CONT, 0, "clr_cont");
        espera(S_VAZIO, 1, "clr_vazio");
        espera(S_VALOR, 0, "clr_valor");
        passo();
        for (int i = 1; i <= 6; i++) armazena(8'(i));
        espera(S_CONT, 4, "full_cont");
        espera(S_CHEIO, 1, "full_cheio");
        espera(S_VALOR, 8'h06, "full_valor");
        resultado_ula = 8'hEE;
        espera(S_FINAL, 8'hEE, "live_before_recall");
        passo();
        recall_passo(2'd0, 8'h06, "rec0");
        recall_passo(2'd1, 8'h05, "rec1");
        recall_passo(2'd2, 8'h04, "rec2");
        recall_passo(2'd3, 8'h03, "rec3");
        recall_passo(2'd0, 8'h06, "rec_wrap");
        recall_passo(2'd1, 8'h05, "rec1b");
        recall_passo(2'd2, 8'h04, "rec2b");

        // Store while browsing history returns to live view
        resultado_ula = 8'h7F;
        executar = 1'b1;
        espera(S_CARREGAR, 1, "hist_store_strobe");
        passo();
        executar = 1'b0;
        espera(S_MODO, 0, "hist_store_modo");
        espera(S_IDX, 0, "hist_store_idx");
        espera(S_VALOR, 8'h7F, "hist_store_valor");
        espera(S_CONT, 4, "hist_store_cont");
        passo();
        resultado_ula = 8'h00;
        recall_passo(2'd0, 8'h7F, "rec_after_store");
        recall_passo(2'd1, 8'h06, "rec_after_store1");

        // limpar and execute edge together
        limpar = 1'b1;
        executar = 1'b1;
        resultado_ula = 8'h99;
        #1;
        espera(S_CARREGAR, 0, "clr_exe_carregar");
        passo();
        espera(S_CONT, 0, "clr_exe_cont");
        espera(S_VAZIO, 1, "clr_exe_vazio");
        espera(S_MODO, 0, "clr_exe_modo");
        espera(S_FINAL, 8'h99, "clr_exe_final");
        limpar = 1'b0;
        executar = 1'b0;
        passo();
        recuperar = 1'b1;
        passo();
        espera(S_MODO, 0, "empty_recall_modo");
        espera(S_IDX, 0, "empty_recall_idx");
        recuperar = 1'b0;
        passo();

        // Asynchronous reset while in history mode
        armazena(8'h44);
        resultado_ula = 8'h12;
        recall_passo(2'd0, 8'h44, "pre_rst_rec");
        #2;
        rst = 1'b1;
        #1;
        espera(S_MODO, 0, "async_rst_modo");
        espera(S_CONT, 0, "async_rst_cont");
        espera(S_VALOR, 0, "async_rst_valor");
        espera(S_IDX, 0, "async_rst_idx");
        espera(S_VAZIO, 1, "async_rst_vazio");
        espera(S_FINAL, 8'h12, "async_rst_final");
        passo();
        passo();
        rst = 1'b0;
        passo();
        passo();
        if (fila.size() != 0) begin
            erros++;
            $display("FAIL drain: got %0d pending, expected 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end
endmodule
